// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM chip responder: command encoding,
// mode-register field positions and burst/CAS-latency decode helpers.
package sdram_pkg;

    // {ras_n, cas_n, we_n} with cs_n=0 and cke=1
    typedef enum logic [2:0] {
        CmdLoadMode  = 3'b000,
        CmdRefresh   = 3'b001,
        CmdPrecharge = 3'b010,
        CmdActive    = 3'b011,
        CmdWrite     = 3'b100,
        CmdRead      = 3'b101,
        CmdBurstTerm = 3'b110,
        CmdNop       = 3'b111
    } cmd_e;

    localparam int unsigned ModeBlLsb = 0;   // A[2:0] burst length code
    localparam int unsigned ModeBtBit = 3;   // A3 burst type (1 = interleaved)
    localparam int unsigned ModeClLsb = 4;   // A[6:4] CAS latency
    localparam int unsigned ModeWbBit = 9;   // A9 single-beat writes
    localparam int unsigned ApBit     = 10;  // A10 precharge all banks

    function automatic cmd_e decode_cmd(input logic cke, input logic cs_n, input logic ras_n,
                                        input logic cas_n, input logic we_n);
        if (!cke || cs_n) begin
            return CmdNop;
        end
        return cmd_e'({ras_n, cas_n, we_n});
    endfunction

    // Index of the last beat for BL code 0..3 (BL 1,2,4,8)
    function automatic logic [2:0] bl_last(input logic [1:0] code);
        case (code)
            2'd0:    return 3'd0;
            2'd1:    return 3'd1;
            2'd2:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic bl_code_ok(input logic [2:0] code);
        return ~code[2];
    endfunction

    function automatic logic cl_code_ok(input logic [2:0] code);
        return (code == 3'd2) || (code == 3'd3);
    endfunction

endpackage

// File: rtl/sdram_resp_store.sv
// Backing store for the SDRAM responder: single-port 2**AW x 16 array with
// per-byte write enables and a registered read. A read access captures the
// array contents before any write in the same cycle.
module sdram_resp_store #(
    parameter int unsigned AW = 12
) (
    input  logic          clock_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [1:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [15:0]   wdata_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [2**AW];
    logic [15:0] rdata_q;

    // Byte-masked write or registered read of one word per cycle
    always_ff @(posedge clock_i) begin
        if (en_i) begin
            if (we_i) begin
                if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
                if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_chip_responder.sv
// Device-side model of a 16-bit SDR SDRAM: command decode, per-bank open-row
// table, mode register (CL 2/3, BL 1/2/4/8, single-beat writes), burst engine
// and CL-deep read pipeline. Optional protocol checker enabled by defining
// SDRAM_RESP_CHECK_EN; otherwise err_o is tied low.
module sdram_chip_responder
    import sdram_pkg::*;
#(
    parameter int unsigned ROW_BITS   = 13,
    parameter int unsigned COL_BITS   = 9,
    parameter int unsigned STORE_AW   = 12,
    parameter int unsigned CL_DEFAULT = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        mem_cke_i,
    input  logic        mem_cs_n_i,
    input  logic        mem_ras_n_i,
    input  logic        mem_cas_n_i,
    input  logic        mem_we_n_i,
    input  logic        mem_udq_i,
    input  logic        mem_ldq_i,
    input  logic [1:0]  mem_ba_i,
    input  logic [12:0] mem_addr_i,
    input  logic [15:0] mem_data_i,
    output logic [15:0] mem_data_o,
    output logic        mem_data_oe_o,
    output logic        err_o,
    output logic [15:0] refresh_cnt_o
);

    cmd_e                cmd;
    logic [3:0]          bank_open_q, bank_open_d;
    logic [ROW_BITS-1:0] bank_row_q [4];
    logic [ROW_BITS-1:0] bank_row_d [4];
    logic [1:0]          bl_code_q, bl_code_d;
    logic                cl3_q, cl3_d;
    logic                wr_single_q, wr_single_d;
    logic                bst_act_q, bst_act_d;
    logic                bst_wr_q, bst_wr_d;
    logic [1:0]          bst_ba_q, bst_ba_d;
    logic [ROW_BITS-1:0] bst_row_q, bst_row_d;
    logic [COL_BITS-1:0] bst_col_q, bst_col_d;
    logic [2:0]          bst_idx_q, bst_idx_d;
    logic [2:0]          bst_last_q, bst_last_d;
    logic                s0_vld_q, s0_vld_d;
    logic                s1_vld_q, s1_vld_d;
    logic [15:0]         s1_data_q, s1_data_d;
    logic [15:0]         dout_q, dout_d;
    logic                oe_q, oe_d;
    logic [15:0]         rfsh_q, rfsh_d;
    logic                acc_en, acc_wr;
    logic [1:0]          acc_ba, acc_be;
    logic [ROW_BITS-1:0] acc_row;
    logic [COL_BITS-1:0] acc_col;
    logic [STORE_AW-1:0] acc_idx;
    logic [15:0]         store_rdata;

    // Sequential column within the BL-aligned block
    function automatic logic [COL_BITS-1:0] wrap_col(input logic [COL_BITS-1:0] base,
                                                     input logic [2:0] idx,
                                                     input logic [2:0] mask);
        wrap_col      = base;
        wrap_col[2:0] = (base[2:0] & ~mask) | ((base[2:0] + idx) & mask);
    endfunction

    // Command decode, burst engine and read pipeline next-state
    always_comb begin
        cmd         = decode_cmd(mem_cke_i, mem_cs_n_i, mem_ras_n_i, mem_cas_n_i, mem_we_n_i);
        bank_open_d = bank_open_q;
        bank_row_d  = bank_row_q;
        bl_code_d   = bl_code_q;
        cl3_d       = cl3_q;
        wr_single_d = wr_single_q;
        bst_act_d   = bst_act_q;
        bst_wr_d    = bst_wr_q;
        bst_ba_d    = bst_ba_q;
        bst_row_d   = bst_row_q;
        bst_col_d   = bst_col_q;
        bst_idx_d   = bst_idx_q;
        bst_last_d  = bst_last_q;
        s0_vld_d    = s0_vld_q;
        s1_vld_d    = s1_vld_q;
        s1_data_d   = s1_data_q;
        dout_d      = dout_q;
        oe_d        = oe_q;
        rfsh_d      = rfsh_q;
        acc_en      = 1'b0;
        acc_wr      = 1'b0;
        acc_ba      = '0;
        acc_row     = '0;
        acc_col     = '0;

        // Continue an ongoing burst unless a command below overrides it
        if (mem_cke_i && bst_act_q) begin
            if (bank_open_q[bst_ba_q]) begin
                acc_en    = 1'b1;
                acc_wr    = bst_wr_q;
                acc_ba    = bst_ba_q;
                acc_row   = bst_row_q;
                acc_col   = wrap_col(bst_col_q, bst_idx_q, bst_last_q);
                bst_idx_d = bst_idx_q + 3'd1;
                bst_act_d = (bst_idx_q != bst_last_q);
            end else begin
                bst_act_d = 1'b0;
            end
        end

        case (cmd)
            CmdActive: begin
                bank_open_d[mem_ba_i] = 1'b1;
                bank_row_d[mem_ba_i]  = mem_addr_i[ROW_BITS-1:0];
            end
            CmdPrecharge: begin
                if (mem_addr_i[ApBit]) bank_open_d = '0;
                else                   bank_open_d[mem_ba_i] = 1'b0;
            end
            CmdRefresh: rfsh_d = rfsh_q + 16'd1;
            CmdLoadMode: begin
                if (bl_code_ok(mem_addr_i[ModeBlLsb +: 3])) begin
                    bl_code_d = mem_addr_i[ModeBlLsb +: 2];
                end
                if (cl_code_ok(mem_addr_i[ModeClLsb +: 3])) begin
                    cl3_d = mem_addr_i[ModeClLsb];
                end
                wr_single_d = mem_addr_i[ModeWbBit];
            end
            CmdBurstTerm: begin
                acc_en    = 1'b0;
                bst_act_d = 1'b0;
            end
            CmdRead, CmdWrite: begin
                acc_en    = 1'b0;
                bst_act_d = 1'b0;
                if (bank_open_q[mem_ba_i]) begin
                    acc_en     = 1'b1;
                    acc_wr     = (cmd == CmdWrite);
                    acc_ba     = mem_ba_i;
                    acc_row    = bank_row_q[mem_ba_i];
                    acc_col    = mem_addr_i[COL_BITS-1:0];
                    bst_last_d = (acc_wr && wr_single_q) ? 3'd0 : bl_last(bl_code_q);
                    bst_act_d  = (bst_last_d != 3'd0);
                    bst_idx_d  = 3'd1;
                    bst_wr_d   = acc_wr;
                    bst_ba_d   = mem_ba_i;
                    bst_row_d  = acc_row;
                    bst_col_d  = acc_col;
                end
            end
            default: ;
        endcase

        // Store read data lands one edge after issue; CL3 adds one more stage
        if (mem_cke_i) begin
            s0_vld_d  = acc_en & ~acc_wr;
            s1_vld_d  = s0_vld_q;
            s1_data_d = store_rdata;
            oe_d      = cl3_q ? s1_vld_q : s0_vld_q;
            dout_d    = oe_d ? (cl3_q ? s1_data_q : store_rdata) : '0;
        end
    end

    assign acc_be  = acc_wr ? ~{mem_udq_i, mem_ldq_i} : 2'b00;
    assign acc_idx = STORE_AW'({acc_row, acc_ba, acc_col});

    // Responder state register with synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            bank_open_q <= '0;
            for (int i = 0; i < 4; i++) bank_row_q[i] <= '0;
            bl_code_q   <= 2'd0;
            cl3_q       <= (CL_DEFAULT == 3);
            wr_single_q <= 1'b0;
            bst_act_q   <= 1'b0;
            bst_wr_q    <= 1'b0;
            bst_ba_q    <= '0;
            bst_row_q   <= '0;
            bst_col_q   <= '0;
            bst_idx_q   <= '0;
            bst_last_q  <= '0;
            s0_vld_q    <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_data_q   <= '0;
            dout_q      <= '0;
            oe_q        <= 1'b0;
            rfsh_q      <= '0;
        end else begin
            bank_open_q <= bank_open_d;
            bank_row_q  <= bank_row_d;
            bl_code_q   <= bl_code_d;
            cl3_q       <= cl3_d;
            wr_single_q <= wr_single_d;
            bst_act_q   <= bst_act_d;
            bst_wr_q    <= bst_wr_d;
            bst_ba_q    <= bst_ba_d;
            bst_row_q   <= bst_row_d;
            bst_col_q   <= bst_col_d;
            bst_idx_q   <= bst_idx_d;
            bst_last_q  <= bst_last_d;
            s0_vld_q    <= s0_vld_d;
            s1_vld_q    <= s1_vld_d;
            s1_data_q   <= s1_data_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            rfsh_q      <= rfsh_d;
        end
    end

    sdram_resp_store #(
        .AW(STORE_AW)
    ) u_store (
        .clock_i (clock_i),
        .en_i    (acc_en),
        .we_i    (acc_wr),
        .be_i    (acc_be),
        .addr_i  (acc_idx),
        .wdata_i (mem_data_i),
        .rdata_o (store_rdata)
    );

`ifdef SDRAM_RESP_CHECK_EN
    logic err_q, err_d, viol;

    // Flag commands illegal for the current bank state or mode encoding
    always_comb begin
        case (cmd)
            CmdActive:         viol = bank_open_q[mem_ba_i];
            CmdRead, CmdWrite: viol = ~bank_open_q[mem_ba_i];
            CmdRefresh:        viol = |bank_open_q;
            CmdLoadMode:       viol = (|bank_open_q) | mem_addr_i[ModeBtBit]
                                      | ~bl_code_ok(mem_addr_i[ModeBlLsb +: 3])
                                      | ~cl_code_ok(mem_addr_i[ModeClLsb +: 3]);
            default:           viol = 1'b0;
        endcase
        err_d = err_q | viol;
    end

    // Sticky error flag
    always_ff @(posedge clock_i) begin
        if (reset_i) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign mem_data_o    = dout_q;
    assign mem_data_oe_o = oe_q;
    assign refresh_cnt_o = rfsh_q;

endmodule

// File: tb/tb_sdram_chip_responder.sv
// Bench for sdram_chip_responder: directed command sequences; expected read
// beats (data and load edge) go into a queue checked by a separate monitor.
module tb_sdram_chip_responder;

    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_LMR = 3'b000;
    localparam logic [2:0] C_BST = 3'b110;

`ifdef SDRAM_RESP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        logic [15:0] d;
        int          c;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        cke = 1'b1;
    logic        cs_n = 1'b0;
    logic        ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic        udq = 1'b0, ldq = 1'b0;
    logic [1:0]  ba = '0;
    logic [12:0] addr = '0;
    logic [15:0] din = '0;
    logic [15:0] dout;
    logic        oe, err;
    logic [15:0] rcnt;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    cl = 2;
    int    n;
    beat_t expq[$];

    sdram_chip_responder dut (
        .clock_i       (clk),
        .reset_i       (reset_i),
        .mem_cke_i     (cke),
        .mem_cs_n_i    (cs_n),
        .mem_ras_n_i   (ras_n),
        .mem_cas_n_i   (cas_n),
        .mem_we_n_i    (we_n),
        .mem_udq_i     (udq),
        .mem_ldq_i     (ldq),
        .mem_ba_i      (ba),
        .mem_addr_i    (addr),
        .mem_data_i    (din),
        .mem_data_o    (dout),
        .mem_data_oe_o (oe),
        .err_o         (err),
        .refresh_cnt_o (rcnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Apply one command across one rising edge, then return to NOP
    task automatic send(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                        input logic [15:0] d, input logic [1:0] dqm);
        {ras_n, cas_n, we_n} = c;
        ba = b;
        addr = a;
        din = d;
        {udq, ldq} = dqm;
        @(posedge clk);
        #1;
        {ras_n, cas_n, we_n} = C_NOP;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) send(C_NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    endtask

    task automatic push(input logic [15:0] d, input int c);
        beat_t b;
        b.d = d;
        b.c = c;
        expq.push_back(b);
    endtask

    // Monitor: every driven beat must match the head of the expected queue
    always @(negedge clk) begin
        if (oe === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h expected no beat (cycle %0d)", dout, cyc);
            end else begin
                beat_t b;
                b = expq.pop_front();
                check("beat_data", {16'd0, dout}, {16'd0, b.d});
                check("beat_cycle", cyc, b.c);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        idle(3);
        check("rst_oe", {31'd0, oe}, 32'd0);
        check("rst_data", {16'd0, dout}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_refresh", {16'd0, rcnt}, 32'd0);
        reset_i = 1'b0;

        // CL2 BL1 basic write/read
        send(C_LMR, 2'd0, 13'h020, 16'd0, 2'b00);
        cl = 2;
        send(C_ACT, 2'd0, 13'd5, 16'd0, 2'b00);
        send(C_WR, 2'd0, 13'h003, 16'hBEEF, 2'b00);
        send(C_RD, 2'd0, 13'h003, 16'd0, 2'b00);
        n = cyc;
        push(16'hBEEF, n + cl - 1);
        idle(3);

        // Byte masks
        send(C_WR, 2'd0, 13'h008, 16'hFFFF, 2'b00);
        send(C_WR, 2'd0, 13'h008, 16'h1234, 2'b10);
        send(C_RD, 2'd0, 13'h008, 16'd0, 2'b00);
        n = cyc;
        push(16'hFF34, n + cl - 1);
        send(C_WR, 2'd0, 13'h009, 16'hFFFF, 2'b00);
        send(C_WR, 2'd0, 13'h009, 16'h1234, 2'b01);
        send(C_RD, 2'd0, 13'h009, 16'd0, 2'b00);
        n = cyc;
        push(16'h12FF, n + cl - 1);
        idle(3);

        // Read in flight, then write same word: read keeps old value
        send(C_RD, 2'd0, 13'h003, 16'd0, 2'b00);
        n = cyc;
        push(16'hBEEF, n + cl - 1);
        send(C_WR, 2'd0, 13'h003, 16'hAAAA, 2'b00);
        send(C_RD, 2'd0, 13'h003, 16'd0, 2'b00);
        n = cyc;
        push(16'hAAAA, n + cl - 1);
        idle(3);

        // CL3 BL4 with wrap inside the aligned block
        send(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
        send(C_LMR, 2'd0, 13'h032, 16'd0, 2'b00);
        cl = 3;
        send(C_ACT, 2'd0, 13'd5, 16'd0, 2'b00);
        send(C_WR, 2'd0, 13'h1FC, 16'd1, 2'b00);
        send(C_NOP, 2'd0, 13'd0, 16'd2, 2'b00);
        send(C_NOP, 2'd0, 13'd0, 16'd3, 2'b00);
        send(C_NOP, 2'd0, 13'd0, 16'd4, 2'b00);
        send(C_RD, 2'd0, 13'h1FE, 16'd0, 2'b00);
        n = cyc;
        push(16'd3, n + cl - 1);
        push(16'd4, n + cl);
        push(16'd1, n + cl + 1);
        push(16'd2, n + cl + 2);
        idle(6);

        // CL2 BL8 cut short by BURST TERMINATE two edges after READ
        send(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
        send(C_LMR, 2'd0, 13'h023, 16'd0, 2'b00);
        cl = 2;
        send(C_ACT, 2'd0, 13'd5, 16'd0, 2'b00);
        send(C_RD, 2'd0, 13'h1FC, 16'd0, 2'b00);
        n = cyc;
        push(16'd1, n + cl - 1);
        push(16'd2, n + cl);
        send(C_NOP, 2'd0, 13'd0, 16'd0, 2'b00);
        send(C_BST, 2'd0, 13'd0, 16'd0, 2'b00);
        idle(4);
        check("bst_oe_low", {31'd0, oe}, 32'd0);

        // Write to closed bank and double ACTIVE
        send(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
        send(C_LMR, 2'd0, 13'h020, 16'd0, 2'b00);
        check("err_clean", {31'd0, err}, 32'd0);
        send(C_ACT, 2'd2, 13'd5, 16'd0, 2'b00);
        send(C_WR, 2'd2, 13'h010, 16'h5A5A, 2'b00);
        send(C_PRE, 2'd2, 13'h000, 16'd0, 2'b00);
        send(C_WR, 2'd2, 13'h010, 16'h0F0F, 2'b00);
        send(C_ACT, 2'd0, 13'd5, 16'd0, 2'b00);
        send(C_ACT, 2'd0, 13'd5, 16'd0, 2'b00);
        send(C_ACT, 2'd2, 13'd5, 16'd0, 2'b00);
        send(C_RD, 2'd2, 13'h010, 16'd0, 2'b00);
        n = cyc;
        push(16'h5A5A, n + cl - 1);
        idle(3);
        check("err_violation", {31'd0, err}, {31'd0, EXP_ERR});

        // Refresh counting, then reset in the middle of a CL3 BL4 read
        send(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
        send(C_REF, 2'd0, 13'd0, 16'd0, 2'b00);
        send(C_REF, 2'd0, 13'd0, 16'd0, 2'b00);
        send(C_REF, 2'd0, 13'd0, 16'd0, 2'b00);
        check("refresh_cnt", {16'd0, rcnt}, 32'd3);
        send(C_LMR, 2'd0, 13'h032, 16'd0, 2'b00);
        cl = 3;
        send(C_ACT, 2'd0, 13'd5, 16'd0, 2'b00);
        send(C_RD, 2'd0, 13'h1FC, 16'd0, 2'b00);
        n = cyc;
        push(16'd1, n + cl - 1);
        idle(2);
        reset_i = 1'b1;
        idle(1);
        check("reset_oe", {31'd0, oe}, 32'd0);
        check("reset_refresh", {16'd0, rcnt}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        reset_i = 1'b0;
        idle(5);
        check("queue_drained", expq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
